// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 8;

    // Width of a requester index; at least one bit so a 1-requester build still elaborates.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after 'last', wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any_valid,
    output logic [ID_W-1:0]    winner
);

    int idx_s;

    // Scan offsets from farthest to nearest so the nearest set bit after 'last' is kept.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx_s     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx_s = (int'(last) + i) % NUM_REQ;
            if (req[idx_s]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx_s);
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory among NUM_REQ requesters.
// Optional per-requester grant counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_in_o,
    input  logic [DATA_W-1:0]         mem_data_out_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt_o
`endif
);

    localparam int ID_W = id_w(NUM_REQ);

    state_e              state_r, state_s;
    logic [ID_W-1:0]     last_r, last_s, id_r, id_s, win_s;
    logic                we_r, we_s, any_s;
    logic [NUM_REQ-1:0]  gnt_r, gnt_s, rvalid_r, rvalid_s;
    logic                mem_read_r, mem_read_s, mem_write_r, mem_write_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_data_r, mem_data_s;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
        .req       (req_i),
        .last      (last_r),
        .any_valid (any_s),
        .winner    (win_s)
    );

    // Next state plus the values every registered output will carry in the next state.
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        id_s        = id_r;
        we_s        = we_r;
        gnt_s       = '0;
        rvalid_s    = '0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_data_s  = mem_data_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s      = ACCESS;
                    last_s       = win_s;
                    id_s         = win_s;
                    we_s         = we_i[win_s];
                    gnt_s[win_s] = 1'b1;
                    mem_write_s  = we_i[win_s];
                    mem_read_s   = ~we_i[win_s];
                    mem_addr_s   = addr_i[win_s*ADDR_W +: ADDR_W];
                    mem_data_s   = wdata_i[win_s*DATA_W +: DATA_W];
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s        = RESP;
                    rvalid_s[id_r] = 1'b1;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, pointer, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            last_r      <= ID_W'(NUM_REQ - 1);
            id_r        <= '0;
            we_r        <= 1'b0;
            gnt_r       <= '0;
            rvalid_r    <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_data_r  <= '0;
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            id_r        <= id_s;
            we_r        <= we_s;
            gnt_r       <= gnt_s;
            rvalid_r    <= rvalid_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            mem_addr_r  <= mem_addr_s;
            mem_data_r  <= mem_data_s;
        end
    end

    assign gnt_o         = gnt_r;
    assign rvalid_o      = rvalid_r;
    assign busy_o        = (state_r != IDLE);
    assign mem_read_o    = mem_read_r;
    assign mem_write_o   = mem_write_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_data_in_o = mem_data_r;

    // The memory registers its read data on the ACCESS edge, so pass it straight through in RESP.
    always_comb begin
        if (state_r == RESP) begin
            rdata_o = mem_data_out_i;
        end else begin
            rdata_o = '0;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_r [NUM_REQ];

    // Saturating grant counters, bumped on the edge that raises the grant.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rst) begin
                cnt_r[k] <= '0;
            end else if (gnt_s[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
                cnt_r[k] <= cnt_r[k] + CNT_W'(1);
            end
        end
    end

    // Pack counters onto the flat output port.
    always_comb begin
        grant_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_o[k*CNT_W +: CNT_W] = cnt_r[k];
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single-port lab memory (`mem`, reached through `mem_interf`) between NUM_REQ requesters.
- Accepts one read or write command at a time, drives the memory read/write strobes, and routes read data back to the winning requester.
- Sits between the requester-side testbench/agents and the memory design in `top`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, memory address width
- DATA_W, 8, memory data width
- CNT_W, 16, width of per-requester grant counters (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_i  in  NUM_REQ  per-requester request, held until gnt_o bit seen
- we_i  in  NUM_REQ  per-requester 1=write, 0=read
- addr_i  in  NUM_REQ*ADDR_W  per-requester address, packed, requester k at [k*ADDR_W +: ADDR_W]
- wdata_i  in  NUM_REQ*DATA_W  per-requester write data, packed likewise
- gnt_o  out  NUM_REQ  one-hot one-cycle accept pulse
- rvalid_o  out  NUM_REQ  one-hot one-cycle read-data-valid pulse
- rdata_o  out  DATA_W  read data, shared, qualified by rvalid_o
- busy_o  out  1  FSM not in IDLE
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_data_in_o  out  DATA_W  memory write data
- mem_data_out_i  in  DATA_W  memory read data, registered by memory on the strobe edge

Behaviour:
- Reset: synchronous, active-high, applied on the rising edge of clk.
  - Sets FSM=IDLE and round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0.
  - An in-flight transaction is dropped; no gnt or rvalid is issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_i is set, pick the winner: the first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - Register winner id, we, addr and wdata; update last to the winner; go to ACCESS.
  - If no req_i is set, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_read_o = ~we and mem_write_o = we, from the latched command.
  - mem_addr_o and mem_data_in_o driven from the latched values.
  - gnt_o[id] = 1.
  - Next state: write -> IDLE; read -> RESP.
- RESP (one cycle):
  - rvalid_o[id] = 1.
  - rdata_o = mem_data_out_i (memory holds it after the read edge).
  - Next state: IDLE.
- Latency: req_i in cycle 0 -> gnt_o in cycle 1 -> read rvalid_o in cycle 2.
- Throughput: write occupancy 2 cycles, read 3 cycles; no back-to-back issue.
- req_i is sampled only in IDLE. Changes to a requester's inputs after the IDLE capture edge have no effect on its transaction.
- Requester deasserts req_i in the cycle after seeing gnt_o. A still-high req_i in IDLE is treated as a new request.
- Strobes are mutually exclusive; both are 0 outside ACCESS.
- mem_addr_o and mem_data_in_o hold their last value outside ACCESS.
- rdata_o is 0 outside RESP.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt_o (NUM_REQ*CNT_W).
  - Counter k increments on each gnt_o[k] and saturates at all-ones.
  - Counters clear on rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state_e enum {IDLE, ACCESS, RESP}
  - default ADDR_W and DATA_W localparams
  - ID_W = $clog2(NUM_REQ) helper function
- Sub-module rr_pick: pure combinational round-robin search.
  - Inputs: req vector, last pointer.
  - Outputs: any-valid flag, winner id.
- The mem_arbiter top owns the FSM, pointer, command registers and counters.

Test Plan:
- Single write then read:
  - Stimulus: req0 write addr=5'h03 data=8'hA5; afterwards req0 read addr=5'h03.
  - Required: gnt_o=4'b0001 one cycle after req; mem_write_o pulse with addr 03/data A5; on the read, rvalid_o[0]=1 with rdata_o=8'hA5 two cycles after the read req.
- Round-robin fairness:
  - Stimulus: all 4 hold read requests continuously, re-requesting after each gnt.
  - Required: grant order 0,1,2,3,0; no requester granted twice before all four are served.
- Wrap and skip:
  - Stimulus: last=2 with only req_i=4'b0010 pending; then req_i=4'b1001.
  - Required: grant 1; then grant 3, then grant 0.
- Input change after capture:
  - Stimulus: req2 write addr=1F data=3C; addr_i changed to 00 in the ACCESS cycle.
  - Required: mem_addr_o=1F, memory[1F]=3C, memory[00] unchanged.
- Reset mid-read:
  - Stimulus: assert rst during ACCESS of a read.
  - Required: next cycle all outputs 0 with FSM in IDLE; no rvalid_o; the next grant goes to requester 0 when several requesters are pending.
- Stats (with MEM_ARB_STATS_EN):
  - Stimulus: 3 grants to requester 1; CNT_W=2 with 5 grants to requester 0.
  - Required: grant_cnt_o for requester 1 = 3; for requester 0 saturates at 2'b11.
